bus_arbiter_rr: RTL and testbench

Parametrised round-robin bus arbiter that serves NUM_MASTERS per-core arbitration submodules sharing one instruction or data bus. It samples one-hot request lines and issues a single registered one-hot grant. The grant is held until the owner releases it or a hold timeout expires. After each tenure it waits for the memory-side ready to drop before granting again, so a new owner never sees a stale ready.

---
 rtl/bus_arbiter_rr_if.sv | 36 +++
 rtl/bus_arbiter_rr.sv | 152 +++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_rr_if.sv
// Bus arbitration interface: request/ready lines from the cores and memory,
// grant and timeout reporting back from the arbiter.
interface bus_arbiter_rr_if #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0] bus_rq;
    logic                   bus_ready;
    logic [NUM_MASTERS-1:0] bus_grant;
    logic                   grant_valid;
    logic [IDX_W-1:0]       grant_idx;
    logic                   timeout_pulse;
    logic [IDX_W-1:0]       timeout_idx;

    // Requester/memory side: drives requests and ready, observes the grant.
    modport master (
        output bus_rq,
        output bus_ready,
        input  bus_grant,
        input  grant_valid,
        input  grant_idx,
        input  timeout_pulse,
        input  timeout_idx
    );

    // Arbiter side: samples requests and ready, drives the grant.
    modport slave (
        input  bus_rq,
        input  bus_ready,
        output bus_grant,
        output grant_valid,
        output grant_idx,
        output timeout_pulse,
        output timeout_idx
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with per-tenure hold timeout, ready-drain turnaround
// and a penalty mask that keeps a forced-off master out until it lets go.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int HOLD_MAX    = 64,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic            clk,
    input  logic            reset,
    bus_arbiter_rr_if.slave bus
);
    // Counter is at least one bit wide so HOLD_MAX=0 still elaborates.
    localparam int HC_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [HC_W-1:0]  HOLD_LAST = (HOLD_MAX > 0) ? HC_W'(HOLD_MAX - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [HC_W-1:0]        hold_cnt, hold_cnt_nxt;
    logic [IDX_W-1:0]       last_idx, last_idx_nxt;
    logic [NUM_MASTERS-1:0] penalty, penalty_nxt;
    logic [NUM_MASTERS-1:0] grant_q, grant_nxt;
    logic                   valid_q;
    logic [IDX_W-1:0]       idx_q, idx_nxt;
    logic                   tpulse_q, tpulse_nxt;
    logic [IDX_W-1:0]       tidx_q, tidx_nxt;

    logic [NUM_MASTERS-1:0] eligible;
    logic [IDX_W-1:0]       cand;
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_found;
    logic                   owner_rq;
    logic                   timeout_hit;
    logic                   forced;

    assign owner_rq    = bus.bus_rq[idx_q];
    assign timeout_hit = (HOLD_MAX != 0) && (hold_cnt == HOLD_LAST);

    // Pick the first eligible master after the previous winner, wrapping around.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        eligible  = bus.bus_rq & ~penalty;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = IDX_W'((int'(last_idx) + k) % NUM_MASTERS);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Next-state, next-grant and penalty-mask logic.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        last_idx_nxt = last_idx;
        grant_nxt    = grant_q;
        idx_nxt      = idx_q;
        tpulse_nxt   = 1'b0;
        tidx_nxt     = tidx_q;
        forced       = 1'b0;

        case (state)
            IDLE: begin
                grant_nxt = '0;
                if (sel_found) begin
                    grant_nxt[sel_idx] = 1'b1;
                    idx_nxt            = sel_idx;
                    last_idx_nxt       = sel_idx;
                    hold_cnt_nxt       = '0;
                    state_nxt          = GRANT;
                end
            end
            GRANT: begin
                // Saturate rather than wrap; only matters when the timeout is off.
                if (hold_cnt != '1) begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
                // An owner dropping rq wins over a coincident timeout.
                if (!owner_rq) begin
                    grant_nxt = '0;
                    state_nxt = RELEASE;
                end else if (timeout_hit) begin
                    grant_nxt  = '0;
                    state_nxt  = RELEASE;
                    tpulse_nxt = 1'b1;
                    tidx_nxt   = idx_q;
                    forced     = 1'b1;
                end
            end
            RELEASE: begin
                grant_nxt = '0;
                // Wait for the old transfer's ready to drop so the next owner
                // never sees it.
                if (!bus.bus_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase

        // A master leaves the penalty box the first edge it is seen idle.
        penalty_nxt = penalty & bus.bus_rq;
        if (forced) begin
            penalty_nxt[idx_q] = 1'b1;
        end
    end

    // State and registered outputs; reset clears the grant immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last_idx <= LAST_RST;
            penalty  <= '0;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            tpulse_q <= 1'b0;
            tidx_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            last_idx <= last_idx_nxt;
            penalty  <= penalty_nxt;
            grant_q  <= grant_nxt;
            valid_q  <= |grant_nxt;
            idx_q    <= idx_nxt;
            tpulse_q <= tpulse_nxt;
            tidx_q   <= tidx_nxt;
        end
    end

    assign bus.bus_grant     = grant_q;
    assign bus.grant_valid   = valid_q;
    assign bus.grant_idx     = idx_q;
    assign bus.timeout_pulse = tpulse_q;
    assign bus.timeout_idx   = tidx_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed vectors, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_bus_arbiter_rr;
    localparam int NM   = 4;
    localparam int HOLD = 8;

    logic clk;
    logic reset;

    bus_arbiter_rr_if #(.NUM_MASTERS(NM)) bif();

    bus_arbiter_rr #(.NUM_MASTERS(NM), .HOLD_MAX(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {grant, valid, idx, timeout_pulse, timeout_idx}
    function automatic logic [9:0] outs();
        return {bif.bus_grant, bif.grant_valid, bif.grant_idx, bif.timeout_pulse, bif.timeout_idx};
    endfunction

    typedef struct {
        logic [3:0] rq;
        logic       rdy;
        logic [3:0] grant;
        logic [1:0] idx;
    } vec_t;

    vec_t vecs[$];

    // ---------------- behavioural reference model ----------------
    int       m_owner;   // -1 when nobody owns the bus
    bit       m_drain;   // tenure over, waiting for ready to drop
    int       m_cycles;  // edges elapsed in the current tenure
    int       m_last;
    bit       m_pen[NM];
    int       m_gidx;
    int       m_tidx;
    bit       m_tpulse;

    task automatic model_reset();
        m_owner  = -1;
        m_drain  = 1'b0;
        m_cycles = 0;
        m_last   = NM - 1;
        m_gidx   = 0;
        m_tidx   = 0;
        m_tpulse = 1'b0;
        for (int i = 0; i < NM; i++) m_pen[i] = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] rq, input logic rdy);
        int was_owner;
        bit forced;
        was_owner = m_owner;
        forced    = 1'b0;
        m_tpulse  = 1'b0;
        if (m_owner >= 0) begin
            m_cycles++;
            if (!rq[m_owner]) begin
                m_owner = -1;
                m_drain = 1'b1;
            end else if (m_cycles == HOLD) begin
                forced   = 1'b1;
                m_tpulse = 1'b1;
                m_tidx   = m_owner;
                m_owner  = -1;
                m_drain  = 1'b1;
            end
        end else if (m_drain) begin
            if (!rdy) m_drain = 1'b0;
        end else begin
            for (int k = 1; k <= NM; k++) begin
                int c;
                c = (m_last + k) % NM;
                if (rq[c] && !m_pen[c]) begin
                    m_owner  = c;
                    m_last   = c;
                    m_gidx   = c;
                    m_cycles = 0;
                    break;
                end
            end
        end
        for (int i = 0; i < NM; i++) if (!rq[i]) m_pen[i] = 1'b0;
        if (forced) m_pen[was_owner] = 1'b1;
    endtask

    function automatic logic [9:0] model_outs();
        logic [3:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return {g, |g, 2'(m_gidx), m_tpulse, 2'(m_tidx)};
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int         order[$];
        int         exp_order[5];
        int         age;
        int         dropped;
        bit         prev_valid;
        int         cycles;
        logic [3:0] rq_v;
        logic       rdy_v;

        exp_order = '{0, 1, 2, 3, 0};

        // Reset state
        reset         = 1'b1;
        bif.bus_rq    = '0;
        bif.bus_ready = 1'b0;
        repeat (50) @(negedge clk);
        check("reset_held", 32'(outs()), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("reset_idle%0d", i), 32'(outs()), 32'h0);
        end

        // Round-robin fairness: each owner drops rq after 3 cycles for one edge
        bif.bus_rq = 4'b1111;
        age        = 0;
        dropped    = -1;
        prev_valid = 1'b0;
        for (int i = 0; i < 80 && order.size() < 5; i++) begin
            tick();
            if (dropped >= 0) begin
                bif.bus_rq[dropped] = 1'b1;
                dropped = -1;
            end
            if (bif.grant_valid && !prev_valid) begin
                order.push_back(int'(bif.grant_idx));
                age = 1;
            end else if (bif.grant_valid) begin
                age++;
            end
            if (bif.grant_valid && age == 3) begin
                dropped = int'(bif.grant_idx);
                bif.bus_rq[dropped] = 1'b0;
            end
            prev_valid = bif.grant_valid;
        end
        check("fair_count", order.size(), 5);
        for (int i = 0; i < order.size() && i < 5; i++)
            check($sformatf("fair_order%0d", i), order[i], exp_order[i]);
        bif.bus_rq = '0;
        repeat (3) tick();

        // Table: single request, turnaround, no preemption, ready wait
        vecs.push_back('{4'b0100, 1'b0, 4'b0100, 2'd2});
        vecs.push_back('{4'b0100, 1'b0, 4'b0100, 2'd2});
        vecs.push_back('{4'b0000, 1'b0, 4'b0000, 2'd2});
        vecs.push_back('{4'b0100, 1'b0, 4'b0000, 2'd2});
        vecs.push_back('{4'b0100, 1'b0, 4'b0100, 2'd2});
        vecs.push_back('{4'b0000, 1'b0, 4'b0000, 2'd2});
        vecs.push_back('{4'b0000, 1'b0, 4'b0000, 2'd2});
        vecs.push_back('{4'b1000, 1'b0, 4'b1000, 2'd3});
        vecs.push_back('{4'b1010, 1'b1, 4'b1000, 2'd3});
        vecs.push_back('{4'b0010, 1'b1, 4'b0000, 2'd3});
        for (int i = 0; i < 5; i++) vecs.push_back('{4'b0010, 1'b1, 4'b0000, 2'd3});
        vecs.push_back('{4'b0010, 1'b0, 4'b0000, 2'd3});
        vecs.push_back('{4'b0010, 1'b0, 4'b0010, 2'd1});
        vecs.push_back('{4'b0000, 1'b0, 4'b0000, 2'd1});
        vecs.push_back('{4'b0000, 1'b0, 4'b0000, 2'd1});
        for (int i = 0; i < vecs.size(); i++) begin
            bif.bus_rq    = vecs[i].rq;
            bif.bus_ready = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d", i), 32'(outs()),
                  32'({vecs[i].grant, |vecs[i].grant, vecs[i].idx, 1'b0, 2'd0}));
        end

        // Timeout: master 3 holds forever, master 0 waits
        bif.bus_ready = 1'b0;
        bif.bus_rq    = 4'b1000;
        tick();
        bif.bus_rq = 4'b1001;
        cycles = 0;
        while (bif.bus_grant == 4'b1000 && cycles < 20) begin
            cycles++;
            tick();
        end
        check("timeout_len", cycles, HOLD);
        check("timeout_pulse", 32'({bif.bus_grant, bif.timeout_pulse, bif.timeout_idx}), 32'({4'b0000, 1'b1, 2'd3}));
        tick();
        check("timeout_pulse_end", 32'({bif.bus_grant, bif.timeout_pulse}), 32'({4'b0000, 1'b0}));
        tick();
        check("after_timeout_grant", 32'({bif.bus_grant, bif.grant_idx}), 32'({4'b0001, 2'd0}));
        bif.bus_rq = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("masked_idle%0d", i), 32'(bif.bus_grant), 32'h0);
        end
        bif.bus_rq = 4'b0000;
        tick();
        bif.bus_rq = 4'b1000;
        tick();
        check("regrant_after_drop", 32'({bif.bus_grant, bif.grant_idx}), 32'({4'b1000, 2'd3}));
        bif.bus_rq = '0;
        repeat (2) tick();

        // Reset in the middle of a tenure
        bif.bus_rq = 4'b0010;
        tick();
        check("pre_reset_grant", 32'(bif.bus_grant), 32'b0010);
        #3;
        reset = 1'b1;
        #1;
        check("reset_async", 32'({bif.bus_grant, bif.grant_valid}), 32'h0);
        bif.bus_rq = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("first_after_reset", 32'({bif.bus_grant, bif.grant_idx}), 32'({4'b0001, 2'd0}));

        // Randomized run against the model
        bif.bus_rq    = '0;
        bif.bus_ready = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        rq_v = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NM; i++)
                if ($urandom_range(5) == 0) rq_v[i] = ~rq_v[i];
            rdy_v         = ($urandom_range(1) == 1);
            bif.bus_rq    = rq_v;
            bif.bus_ready = rdy_v;
            tick();
            model_edge(rq_v, rdy_v);
            check($sformatf("rand%0d", n), 32'(outs()), 32'(model_outs()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
